// File: rtl/maxnet_pkg.sv
// Shared constants and state encoding for the Maxnet operand store.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package maxnet_pkg;

  // Default datapath geometry: 5-bit Q2.3 words, 4 activations.
  localparam int DEF_WIDTH = 5;
  localparam int DEF_N     = 4;

  // Reset weight pair: +1.0 on the diagonal, -epsilon (-0.25) elsewhere.
  localparam logic [DEF_WIDTH-1:0] DEF_DIAG = 5'b01000;
  localparam logic [DEF_WIDTH-1:0] DEF_OFF  = 5'b11110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/maxnet_wrow_gen.sv
// Builds one flattened W row from the diag/off pair; rows >= N yield all-zero.
// Latency: combinational.
// Backpressure: none.
// Ports: row (row index), diag/off (weight pair), w (entry j at [j*WIDTH +: WIDTH]).
module maxnet_wrow_gen #(
  parameter int WIDTH = 5,
  parameter int N     = 4,
  parameter int AW    = 2
) (
  input  logic [AW-1:0]      row,
  input  logic [WIDTH-1:0]   diag,
  input  logic [WIDTH-1:0]   off,
  output logic [N*WIDTH-1:0] w
);

  logic row_ok;

  // Only an index space wider than N can hold an out-of-range row.
  generate
    if (N < (1 << AW)) begin : g_partial
      assign row_ok = (row < AW'(N));
    end else begin : g_full
      assign row_ok = 1'b1;
    end
  endgenerate

  always_comb begin
    w = '0;
    if (row_ok) begin
      for (int j = 0; j < N; j++) begin
        w[j*WIDTH +: WIDTH] = (AW'(j) == row) ? diag : off;
      end
    end
  end

endmodule

// File: rtl/maxnet_mem.sv
// Operand store for Maxnet: serially loaded X vector, in-place writeback, generated W rows.
// Latency: read 1 cycle (rd_en -> rd_valid), writeback/load/cfg land on the next edge.
// Backpressure: ld_ready high only in LOAD; reads/writebacks are dropped outside READY.
// Ports: clk/rst_n; ld_* serial loader; cfg_* weight pair; rd_* row read; wb_* writeback; nz_count.
module maxnet_mem
  import maxnet_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               N         = DEF_N,
  parameter logic [WIDTH-1:0] DIAG_INIT = DEF_DIAG,
  parameter logic [WIDTH-1:0] OFF_INIT  = DEF_OFF,
  parameter int               AW        = idx_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_start,
  input  logic               ld_valid,
  input  logic [WIDTH-1:0]   ld_data,
  output logic               ld_ready,
  output logic               loaded,
  input  logic               cfg_we,
  input  logic [WIDTH-1:0]   cfg_diag,
  input  logic [WIDTH-1:0]   cfg_off,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_row,
  output logic               rd_valid,
  output logic [N*WIDTH-1:0] rd_x,
  output logic [N*WIDTH-1:0] rd_w,
  input  logic               wb_en,
  input  logic [AW-1:0]      wb_addr,
  input  logic [WIDTH-1:0]   wb_data,
  output logic [AW:0]        nz_count
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  state_t             state_q, state_d;
  logic [AW-1:0]      idx_q;
  logic [WIDTH-1:0]   x_q [N];
  logic               loaded_q;
  logic [WIDTH-1:0]   diag_q, off_q;
  logic               rd_valid_q;
  logic [N*WIDTH-1:0] rd_x_q, rd_w_q;

  logic               ld_acc, rd_acc, wb_acc, wb_in_range;
  logic [N*WIDTH-1:0] x_flat, w_row;

  generate
    if (N < (1 << AW)) begin : g_wb_partial
      assign wb_in_range = (wb_addr < AW'(N));
    end else begin : g_wb_full
      assign wb_in_range = 1'b1;
    end
  endgenerate

  // FSM next state plus per-cycle accept strobes.
  // ld_start wins over a same-cycle beat, so ld_ready drops while restarting.
  always_comb begin
    state_d  = state_q;
    ld_ready = 1'b0;
    ld_acc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ld_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        ld_ready = !ld_start;
        ld_acc   = ld_valid && !ld_start;
        if (ld_start)                         state_d = ST_LOAD;
        else if (ld_acc && idx_q == LAST_IDX) state_d = ST_READY;
      end
      ST_READY: begin
        if (ld_start) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
    rd_acc = (state_q == ST_READY) && rd_en;
    wb_acc = (state_q == ST_READY) && wb_en && wb_in_range;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      loaded_q <= 1'b0;
    end else if (ld_start) begin
      idx_q    <= '0;
      loaded_q <= 1'b0;
    end else if (ld_acc) begin
      idx_q <= idx_q + 1'b1;
      if (idx_q == LAST_IDX) loaded_q <= 1'b1;
    end
  end

  // Load beats and writebacks never coincide: one needs LOAD, the other READY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) x_q[i] <= '0;
    end else if (ld_acc) begin
      x_q[idx_q] <= ld_data;
    end else if (wb_acc) begin
      x_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diag_q <= DIAG_INIT;
      off_q  <= OFF_INIT;
    end else if (cfg_we) begin
      diag_q <= cfg_diag;
      off_q  <= cfg_off;
    end
  end

  always_comb begin
    x_flat = '0;
    for (int i = 0; i < N; i++) x_flat[i*WIDTH +: WIDTH] = x_q[i];
  end

  maxnet_wrow_gen #(
    .WIDTH (WIDTH),
    .N     (N),
    .AW    (AW)
  ) u_wrow (
    .row  (rd_row),
    .diag (diag_q),
    .off  (off_q),
    .w    (w_row)
  );

  // Snapshot is taken from the pre-edge registers, so a same-cycle
  // writeback or cfg write is not visible in this read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_x_q     <= '0;
      rd_w_q     <= '0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_x_q <= x_flat;
        rd_w_q <= w_row;
      end
    end
  end

  // Strictly positive in two's complement: sign bit clear and not zero.
  always_comb begin
    nz_count = '0;
    for (int i = 0; i < N; i++) begin
      if (!x_q[i][WIDTH-1] && (x_q[i] != '0)) nz_count = nz_count + 1'b1;
    end
  end

  assign loaded   = loaded_q;
  assign rd_valid = rd_valid_q;
  assign rd_x     = rd_x_q;
  assign rd_w     = rd_w_q;

endmodule

// File: tb/tb_maxnet_mem.sv
module tb_maxnet_mem;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ld_start = 1'b0, ld_valid = 1'b0;
  logic [4:0] ld_data = '0;
  logic       cfg_we = 1'b0;
  logic [4:0] cfg_diag = '0, cfg_off = '0;
  logic       rd_en = 1'b0;
  logic [1:0] rd_row = '0;
  logic       wb_en = 1'b0;
  logic [1:0] wb_addr = '0;
  logic [4:0] wb_data = '0;

  logic        ld_ready4, loaded4, rd_valid4;
  logic [19:0] rd_x4, rd_w4;
  logic [2:0]  nz4;
  logic        ld_ready3, loaded3, rd_valid3;
  logic [14:0] rd_x3, rd_w3;
  logic [2:0]  nz3;

  always #5 clk = ~clk;

  maxnet_mem #(.WIDTH(5), .N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready4), .loaded(loaded4), .cfg_we(cfg_we), .cfg_diag(cfg_diag), .cfg_off(cfg_off),
    .rd_en(rd_en), .rd_row(rd_row), .rd_valid(rd_valid4), .rd_x(rd_x4), .rd_w(rd_w4),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .nz_count(nz4));

  // N=3 still has a 2-bit index, so row/addr 3 exercise out-of-range handling.
  maxnet_mem #(.WIDTH(5), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready3), .loaded(loaded3), .cfg_we(cfg_we), .cfg_diag(cfg_diag), .cfg_off(cfg_off),
    .rd_en(rd_en), .rd_row(rd_row), .rd_valid(rd_valid3), .rd_x(rd_x3), .rd_w(rd_w3),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .nz_count(nz3));

  int passed = 0;
  int total  = 0;

  // Reference model, index 0 = N=4 instance, index 1 = N=3 instance.
  // mode: 0 = waiting for a load, 1 = loading, 2 = store usable.
  int         nn [2] = '{4, 3};
  logic [4:0] xm [2][4];
  int         mode [2];
  int         midx [2];
  logic       mloaded [2];
  logic [4:0] mdiag, moff;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [19:0] m_xflat(input int k);
    logic [19:0] r = '0;
    for (int i = 0; i < nn[k]; i++) r[i*5 +: 5] = xm[k][i];
    return r;
  endfunction

  function automatic logic [19:0] m_wrow(input int k, input int row);
    logic [19:0] r = '0;
    if (row >= nn[k]) return r;
    for (int j = 0; j < nn[k]; j++) r[j*5 +: 5] = (j == row) ? mdiag : moff;
    return r;
  endfunction

  function automatic logic [2:0] m_nz(input int k);
    int c = 0;
    for (int i = 0; i < nn[k]; i++) if ($signed(xm[k][i]) > 0) c++;
    return 3'(c);
  endfunction

  function automatic logic o_ldr(input int k);     return k == 0 ? ld_ready4 : ld_ready3; endfunction
  function automatic logic o_loaded(input int k);  return k == 0 ? loaded4   : loaded3;   endfunction
  function automatic logic o_valid(input int k);   return k == 0 ? rd_valid4 : rd_valid3; endfunction
  function automatic logic [19:0] o_x(input int k); return k == 0 ? rd_x4 : {5'b0, rd_x3}; endfunction
  function automatic logic [19:0] o_w(input int k); return k == 0 ? rd_w4 : {5'b0, rd_w3}; endfunction
  function automatic logic [2:0] o_nz(input int k); return k == 0 ? nz4 : nz3; endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) xm[k][i] = '0;
      mode[k] = 0; midx[k] = 0; mloaded[k] = 1'b0;
    end
    mdiag = 5'b01000;
    moff  = 5'b11110;
  endtask

  task automatic idle_inputs();
    ld_start = 0; ld_valid = 0; rd_en = 0; wb_en = 0; cfg_we = 0;
  endtask

  // One clock with whatever inputs the caller has driven, then back to idle.
  task automatic cyc();
    logic        ev [2];
    logic [19:0] ex [2], ew [2];
    int          pre [2];
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ld_ready_n%0d", nn[k]), o_ldr(k), mode[k] == 1 && !ld_start);
      ev[k]  = (mode[k] == 2) && rd_en;
      ex[k]  = m_xflat(k);
      ew[k]  = m_wrow(k, int'(rd_row));
      pre[k] = mode[k];
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (ld_start) begin
        mode[k] = 1; midx[k] = 0; mloaded[k] = 1'b0;
      end else if (mode[k] == 1 && ld_valid) begin
        xm[k][midx[k]] = ld_data;
        midx[k]++;
        if (midx[k] == nn[k]) begin mode[k] = 2; mloaded[k] = 1'b1; end
      end
      if (pre[k] == 2 && wb_en && int'(wb_addr) < nn[k]) xm[k][wb_addr] = wb_data;
    end
    if (cfg_we) begin mdiag = cfg_diag; moff = cfg_off; end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rd_valid_n%0d", nn[k]), o_valid(k), ev[k]);
      if (ev[k]) begin
        chk($sformatf("rd_x_n%0d", nn[k]), o_x(k), ex[k]);
        chk($sformatf("rd_w_n%0d", nn[k]), o_w(k), ew[k]);
      end
      chk($sformatf("loaded_n%0d", nn[k]), o_loaded(k), mloaded[k]);
      chk($sformatf("nz_count_n%0d", nn[k]), o_nz(k), m_nz(k));
    end
    idle_inputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ld_ready_n%0d", nn[k]), o_ldr(k), 1'b0);
      chk($sformatf("rst_loaded_n%0d", nn[k]), o_loaded(k), 1'b0);
      chk($sformatf("rst_rd_valid_n%0d", nn[k]), o_valid(k), 1'b0);
      chk($sformatf("rst_rd_x_n%0d", nn[k]), o_x(k), 20'd0);
      chk($sformatf("rst_rd_w_n%0d", nn[k]), o_w(k), 20'd0);
      chk($sformatf("rst_nz_n%0d", nn[k]), o_nz(k), 3'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] d);
    logic [4:0] v [4];
    v = '{a, b, c, d};
    ld_start = 1; cyc();
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_data = v[i]; cyc();
    end
  endtask

  initial begin
    idle_inputs();
    #1;
    do_reset();

    // Serial load of the reference vector.
    load4(5'b00011, 5'b00101, 5'b11100, 5'b00010);
    chk("load_loaded", loaded4, 1'b1);
    chk("load_nz", nz4, 3'd3);
    chk("load_ld_ready", ld_ready4, 1'b0);

    // Row 2 with reset weights.
    rd_en = 1; rd_row = 2; cyc();
    chk("row2_w", rd_w4, {5'b11110, 5'b01000, 5'b11110, 5'b11110});
    chk("row2_x", rd_x4, {5'b00010, 5'b11100, 5'b00101, 5'b00011});

    // Read and writeback of X[0] in the same cycle: read sees the old value.
    rd_en = 1; rd_row = 0; wb_en = 1; wb_addr = 0; wb_data = 5'b00000; cyc();
    chk("rdwb_old_x0", rd_x4[4:0], 5'b00011);
    rd_en = 1; rd_row = 0; cyc();
    chk("rdwb_new_x0", rd_x4[4:0], 5'b00000);
    chk("rdwb_nz", nz4, 3'd2);

    // New weight pair, then row 3; N=3 instance must zero row 3.
    cfg_we = 1; cfg_diag = 5'b00111; cfg_off = 5'b11111; cyc();
    rd_en = 1; rd_row = 3; cyc();
    chk("cfg_row3_w", rd_w4, {5'b00111, 5'b11111, 5'b11111, 5'b11111});
    chk("oor_row_w", rd_w3, 15'd0);
    chk("oor_row_valid", rd_valid3, 1'b1);

    // wb_addr 3 is dropped by the N=3 instance.
    wb_en = 1; wb_addr = 3; wb_data = 5'b01111; cyc();
    rd_en = 1; rd_row = 0; cyc();
    chk("oor_wb_x", rd_x3, {5'b11100, 5'b00101, 5'b00000});

    // Reset after two load beats, then a fresh load.
    ld_start = 1; cyc();
    ld_valid = 1; ld_data = 5'b01010; cyc();
    ld_valid = 1; ld_data = 5'b10001; cyc();
    do_reset();
    load4(5'b11111, 5'b00001, 5'b00000, 5'b01111);
    for (int r = 0; r < 4; r++) begin
      rd_en = 1; rd_row = 2'(r); cyc();
    end
    chk("reload_x", rd_x4, {5'b01111, 5'b00000, 5'b00001, 5'b11111});

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      ld_start = ($urandom_range(0, 39) == 0);
      ld_valid = $urandom_range(0, 1);
      ld_data  = 5'($urandom);
      rd_en    = $urandom_range(0, 1);
      rd_row   = 2'($urandom);
      wb_en    = $urandom_range(0, 1);
      wb_addr  = 2'($urandom);
      wb_data  = 5'($urandom);
      cfg_we   = ($urandom_range(0, 9) == 0);
      cfg_diag = 5'($urandom);
      cfg_off  = 5'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
